// File: rtl/axi4_dma_pkg.sv
// Shared definitions for the AXI4 DMA read/write engines: FSM states,
// AXI encodings, 4 KiB alignment mask and the AxSIZE helper.
package axi4_dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } dma_state_e;

    localparam logic [1:0]  BURST_INCR    = 2'b01;
    localparam logic [1:0]  RESP_OKAY     = 2'b00;
    localparam logic [63:0] ALIGN_4K_MASK = 64'hFFFF_FFFF_FFFF_F000;

    // AxSIZE encoding is log2 of the bus width in bytes.
    function automatic logic [2:0] axsize_of(input int data_w);
        logic [2:0] size_v;
        size_v = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == (data_w / 8)) begin
                size_v = 3'(i);
            end
        end
        return size_v;
    endfunction

endpackage

// File: rtl/axi4_dma_read.sv
// AXI4 read-master DMA: issues num_burst aligned INCR bursts and forwards the
// returned beats to a valid/ready stream. Optional AXI4_DMA_READ_CHECKSUM_EN adds io_checksum.
module axi4_dma_read
    import axi4_dma_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 512,
    parameter int ID_W        = 1,
    parameter int BURST_BEATS = 64,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic              io_axi_arvalid,
    input  logic              io_axi_arready,
    output logic [ADDR_W-1:0] io_axi_araddr,
    output logic [ID_W-1:0]   io_axi_arid,
    output logic [7:0]        io_axi_arlen,
    output logic [2:0]        io_axi_arsize,
    output logic [1:0]        io_axi_arburst,
    input  logic              io_axi_rvalid,
    output logic              io_axi_rready,
    input  logic [DATA_W-1:0] io_axi_rdata,
    input  logic [ID_W-1:0]   io_axi_rid,
    input  logic [1:0]        io_axi_rresp,
    input  logic              io_axi_rlast,
    output logic              io_rd_valid,
    input  logic              io_rd_ready,
    output logic [DATA_W-1:0] io_rd_data,
    input  logic [ADDR_W-1:0] io_start_addr,
    input  logic [CNT_W-1:0]  io_num_burst,
    input  logic              io_ap_start,
    output logic              io_ap_ready,
    output logic              io_ap_done,
    output logic              io_ap_idle,
    output logic              io_err
`ifdef AXI4_DMA_READ_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] io_checksum
`endif
);

    localparam int                BEAT_W    = $clog2(BURST_BEATS) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_BEATS * (DATA_W / 8));

    dma_state_e        r_state;
    dma_state_e        w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_num_burst;
    logic [CNT_W-1:0]  r_burst_cnt;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic              r_err;
    logic              w_r_hs;
    logic              w_final_burst;
    logic              w_unused;

    assign io_axi_araddr  = r_addr;
    assign io_axi_arid    = {ID_W{1'b0}};
    assign io_axi_arlen   = 8'(BURST_BEATS - 1);
    assign io_axi_arsize  = axsize_of(DATA_W);
    assign io_axi_arburst = BURST_INCR;
    assign io_rd_data     = io_axi_rdata;
    assign io_err         = r_err;
    assign w_final_burst  = (r_burst_cnt == (r_num_burst - CNT_W'(1)));
    assign w_unused       = ^io_axi_rid;

    // Next-state decode and state-decoded handshake/status outputs.
    always_comb begin
        w_next_state   = r_state;
        io_axi_arvalid = 1'b0;
        io_axi_rready  = 1'b0;
        io_rd_valid    = 1'b0;
        io_ap_idle     = 1'b0;
        io_ap_done     = 1'b0;
        io_ap_ready    = 1'b0;
        w_r_hs         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                io_ap_idle = 1'b1;
                if (io_ap_start) begin
                    if (io_num_burst == {CNT_W{1'b0}}) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_ADDR;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ADDR: begin
                io_axi_arvalid = 1'b1;
                if (io_axi_arready) begin
                    w_next_state = ST_DATA;
                end else begin
                    w_next_state = ST_ADDR;
                end
            end
            ST_DATA: begin
                io_axi_rready = io_rd_ready;
                io_rd_valid   = io_axi_rvalid;
                w_r_hs        = io_axi_rvalid & io_rd_ready;
                // Only rlast moves the FSM, even when it arrives at the wrong beat.
                if (w_r_hs && io_axi_rlast) begin
                    if (w_final_burst) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_next_state = ST_ADDR;
                    end
                end else begin
                    w_next_state = ST_DATA;
                end
            end
            ST_DONE: begin
                io_ap_done   = 1'b1;
                io_ap_ready  = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register, address/counters and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= {ADDR_W{1'b0}};
            r_num_burst <= {CNT_W{1'b0}};
            r_burst_cnt <= {CNT_W{1'b0}};
            r_beat_cnt  <= {BEAT_W{1'b0}};
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (io_ap_start) begin
                        r_addr      <= io_start_addr & ALIGN_4K_MASK[ADDR_W-1:0];
                        r_num_burst <= io_num_burst;
                        r_burst_cnt <= {CNT_W{1'b0}};
                        r_beat_cnt  <= {BEAT_W{1'b0}};
                        r_err       <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (w_r_hs) begin
                        if ((io_axi_rresp != RESP_OKAY) ||
                            (io_axi_rlast != (r_beat_cnt == LAST_BEAT))) begin
                            r_err <= 1'b1;
                        end
                        if (io_axi_rlast) begin
                            r_beat_cnt  <= {BEAT_W{1'b0}};
                            r_addr      <= r_addr + ADDR_STEP;
                            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
                        end else begin
                            r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef AXI4_DMA_READ_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    assign io_checksum = r_checksum;

    // Running XOR of every accepted beat since the last start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_checksum <= {DATA_W{1'b0}};
        end else if ((r_state == ST_IDLE) && io_ap_start) begin
            r_checksum <= {DATA_W{1'b0}};
        end else if (w_r_hs) begin
            r_checksum <= r_checksum ^ io_axi_rdata;
        end
    end
`endif

endmodule

// File: tb/tb_axi4_dma_read.sv
// Self-checking bench for axi4_dma_read: memory-slave model, expected-stream
// scoreboard and directed scenarios (define AXI4_DMA_READ_CHECKSUM_EN for checksum test).
module tb_axi4_dma_read;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 512;
    localparam int ID_W   = 1;
    localparam int BB     = 64;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              io_axi_arvalid, io_axi_arready;
    logic [ADDR_W-1:0] io_axi_araddr;
    logic [ID_W-1:0]   io_axi_arid;
    logic [7:0]        io_axi_arlen;
    logic [2:0]        io_axi_arsize;
    logic [1:0]        io_axi_arburst;
    logic              io_axi_rvalid, io_axi_rready;
    logic [DATA_W-1:0] io_axi_rdata;
    logic [ID_W-1:0]   io_axi_rid;
    logic [1:0]        io_axi_rresp;
    logic              io_axi_rlast;
    logic              io_rd_valid, io_rd_ready;
    logic [DATA_W-1:0] io_rd_data;
    logic [ADDR_W-1:0] io_start_addr;
    logic [CNT_W-1:0]  io_num_burst;
    logic              io_ap_start, io_ap_ready, io_ap_done, io_ap_idle, io_err;
`ifdef AXI4_DMA_READ_CHECKSUM_EN
    logic [DATA_W-1:0] io_checksum;
`endif

    always #5 clk = ~clk;

    axi4_dma_read #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .BURST_BEATS(BB), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .io_axi_arvalid(io_axi_arvalid), .io_axi_arready(io_axi_arready),
        .io_axi_araddr(io_axi_araddr), .io_axi_arid(io_axi_arid),
        .io_axi_arlen(io_axi_arlen), .io_axi_arsize(io_axi_arsize),
        .io_axi_arburst(io_axi_arburst),
        .io_axi_rvalid(io_axi_rvalid), .io_axi_rready(io_axi_rready),
        .io_axi_rdata(io_axi_rdata), .io_axi_rid(io_axi_rid),
        .io_axi_rresp(io_axi_rresp), .io_axi_rlast(io_axi_rlast),
        .io_rd_valid(io_rd_valid), .io_rd_ready(io_rd_ready), .io_rd_data(io_rd_data),
        .io_start_addr(io_start_addr), .io_num_burst(io_num_burst),
        .io_ap_start(io_ap_start), .io_ap_ready(io_ap_ready),
        .io_ap_done(io_ap_done), .io_ap_idle(io_ap_idle), .io_err(io_err)
`ifdef AXI4_DMA_READ_CHECKSUM_EN
        , .io_checksum(io_checksum)
`endif
    );

    int                n_checks = 0;
    int                n_pass   = 0;
    int                beats_seen = 0;
    bit                pat_k = 1'b0;
    logic [DATA_W-1:0] exp_data_q[$];
    logic [ADDR_W-1:0] exp_ar_q[$];
    logic [ADDR_W-1:0] ar_log[$];

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory contents: each beat is its 32-bit address-plus-beat tag replicated, or k replicated.
    function automatic logic [DATA_W-1:0] beat_word(input logic [ADDR_W-1:0] a, input int b);
        logic [31:0] tag;
        tag = pat_k ? 32'(b) : (a + 32'(b));
        return {16{tag}};
    endfunction

    // Per-cycle compare of AR fields, stream pass-through and in-order beat data.
    always @(negedge clk) begin
        if (!reset) begin
            if (io_axi_arvalid && io_axi_arready) begin
                ar_log.push_back(io_axi_araddr);
                if (exp_ar_q.size() == 0) begin
                    chk("ar_unexpected", DATA_W'(io_axi_arvalid), DATA_W'(0));
                end else begin
                    chk("araddr", DATA_W'(io_axi_araddr), DATA_W'(exp_ar_q.pop_front()));
                end
                chk("arlen", DATA_W'(io_axi_arlen), DATA_W'(63));
                chk("arsize", DATA_W'(io_axi_arsize), DATA_W'(6));
                chk("arburst", DATA_W'(io_axi_arburst), DATA_W'(1));
                chk("arid", DATA_W'(io_axi_arid), DATA_W'(0));
            end
            if (io_axi_rvalid) begin
                chk("rready_mirror", DATA_W'(io_axi_rready), DATA_W'(io_rd_ready));
                chk("rd_valid", DATA_W'(io_rd_valid), DATA_W'(1));
                chk("rd_data_pass", io_rd_data, io_axi_rdata);
            end else begin
                chk("rd_valid_idle", DATA_W'(io_rd_valid), DATA_W'(0));
            end
            if (io_rd_valid && io_rd_ready) begin
                beats_seen++;
                if (exp_data_q.size() == 0) begin
                    chk("beat_extra", DATA_W'(io_rd_valid), DATA_W'(0));
                end else begin
                    chk("beat_data", io_rd_data, exp_data_q.pop_front());
                end
            end
        end
    end

    task automatic run(input logic [31:0] sa, input logic [15:0] nb, input int resp_beat,
                       input int short_len, input bit rnd_rdy, input int rst_beat, input bit exp_err);
        logic [31:0]       base;
        logic [31:0]       cur;
        logic [DATA_W-1:0] exp_ck;
        int                bursts_done, beat, len, cyc, last_cyc, n_r, l;
        bit                active, done_seen, aborted, hs_ar, hs_r;
        base = sa & 32'hFFFF_F000;
        exp_ck = '0;
        bursts_done = 0; beat = 0; len = 0; cyc = 0; last_cyc = -10; n_r = 0;
        active = 1'b0; done_seen = 1'b0; aborted = 1'b0; cur = 32'd0;
        exp_data_q.delete(); exp_ar_q.delete(); ar_log.delete(); beats_seen = 0;
        for (int k = 0; k < int'(nb); k++) begin
            exp_ar_q.push_back(base + 32'(k) * 32'h1000);
            l = (k == 0 && short_len > 0) ? short_len : BB;
            for (int b = 0; b < l; b++) begin
                exp_data_q.push_back(beat_word(base + 32'(k) * 32'h1000, b));
                exp_ck = exp_ck ^ beat_word(base + 32'(k) * 32'h1000, b);
            end
        end
        @(posedge clk); #1;
        io_ap_start = 1'b1; io_start_addr = sa; io_num_burst = nb;
        @(posedge clk); #1;
        io_ap_start = 1'b0; io_start_addr = 32'hDEAD_BEEF; io_num_burst = 16'hFFFF;
        @(negedge clk);
        chk("err_cleared_on_start", DATA_W'(io_err), DATA_W'(0));
        chk("arvalid_after_start", DATA_W'(io_axi_arvalid), DATA_W'(nb != 16'd0));
        chk("done_zero_burst", DATA_W'(io_ap_done), DATA_W'(nb == 16'd0));
        chk("ready_zero_burst", DATA_W'(io_ap_ready), DATA_W'(nb == 16'd0));
        chk("idle_after_start", DATA_W'(io_ap_idle), DATA_W'(0));
        done_seen = (nb == 16'd0);
        hs_ar = io_axi_arvalid & io_axi_arready;
        if (hs_ar) cur = io_axi_araddr;
        hs_r = 1'b0;
        while (!done_seen && !aborted && cyc < 4000) begin
            @(posedge clk); #1;
            if (hs_ar) begin
                active = 1'b1; beat = 0;
                len = (bursts_done == 0 && short_len > 0) ? short_len : BB;
            end else if (hs_r) begin
                beat++; n_r++;
                if (beat == len) begin
                    active = 1'b0; bursts_done++;
                end
            end
            if (rst_beat >= 0 && n_r == rst_beat) begin
                reset = 1'b1; io_axi_rvalid = 1'b0; io_axi_rlast = 1'b0; aborted = 1'b1;
            end else begin
                io_axi_rvalid = active;
                io_axi_rdata  = active ? beat_word(cur, beat) : '0;
                io_axi_rlast  = active && (beat == len - 1);
                io_axi_rresp  = (active && bursts_done == 0 && beat == resp_beat) ? 2'b10 : 2'b00;
                io_rd_ready   = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (!aborted) begin
                if (io_ap_done) begin
                    done_seen = 1'b1;
                    chk("done_after_last", DATA_W'(cyc), DATA_W'(last_cyc + 1));
                    chk("ap_ready_with_done", DATA_W'(io_ap_ready), DATA_W'(1));
                    chk("err_at_done", DATA_W'(io_err), DATA_W'(exp_err));
`ifdef AXI4_DMA_READ_CHECKSUM_EN
                    chk("checksum", io_checksum, exp_ck);
`endif
                end
                hs_ar = io_axi_arvalid & io_axi_arready;
                if (hs_ar) cur = io_axi_araddr;
                hs_r = io_axi_rvalid & io_axi_rready;
                if (hs_r && io_axi_rlast) last_cyc = cyc;
            end
        end
        io_axi_rvalid = 1'b0; io_axi_rlast = 1'b0; io_rd_ready = 1'b1;
        if (aborted) begin
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            chk("rst_mid_idle", DATA_W'(io_ap_idle), DATA_W'(1));
            chk("rst_mid_arvalid", DATA_W'(io_axi_arvalid), DATA_W'(0));
            chk("rst_mid_rready", DATA_W'(io_axi_rready), DATA_W'(0));
            chk("rst_mid_err", DATA_W'(io_err), DATA_W'(0));
            exp_data_q.delete(); exp_ar_q.delete();
        end else begin
            if (!done_seen) chk("timeout_done", DATA_W'(done_seen), DATA_W'(1));
            @(negedge clk);
            chk("idle_after_done", DATA_W'(io_ap_idle), DATA_W'(1));
            chk("done_one_cycle", DATA_W'(io_ap_done), DATA_W'(0));
            chk("all_beats", DATA_W'(exp_data_q.size()), DATA_W'(0));
            chk("all_ars", DATA_W'(exp_ar_q.size()), DATA_W'(0));
        end
    endtask

    initial begin
        reset = 1'b1;
        io_axi_arready = 1'b1; io_axi_rvalid = 1'b0; io_axi_rdata = '0; io_axi_rid = '0;
        io_axi_rresp = 2'b00; io_axi_rlast = 1'b0; io_rd_ready = 1'b1;
        io_start_addr = '0; io_num_burst = '0; io_ap_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_idle", DATA_W'(io_ap_idle), DATA_W'(1));
        chk("rst_done", DATA_W'(io_ap_done), DATA_W'(0));
        chk("rst_ready", DATA_W'(io_ap_ready), DATA_W'(0));
        chk("rst_err", DATA_W'(io_err), DATA_W'(0));
        chk("rst_arvalid", DATA_W'(io_axi_arvalid), DATA_W'(0));
        chk("rst_rready", DATA_W'(io_axi_rready), DATA_W'(0));
        chk("rst_rd_valid", DATA_W'(io_rd_valid), DATA_W'(0));

        // Two full bursts, always ready.
        run(32'h0000_1234, 16'd2, -1, 0, 1'b0, -1, 1'b0);
        chk("t1_ar0", DATA_W'(ar_log[0]), DATA_W'(32'h0000_1000));
        chk("t1_ar1", DATA_W'(ar_log[1]), DATA_W'(32'h0000_2000));
        chk("t1_beats", DATA_W'(beats_seen), DATA_W'(128));

        // Same transfer with downstream backpressure.
        run(32'h0000_1234, 16'd2, -1, 0, 1'b1, -1, 1'b0);
        chk("t2_beats", DATA_W'(beats_seen), DATA_W'(128));

        // SLVERR on beat 5, with address wrap past 2^32.
        run(32'hFFFF_F567, 16'd2, 5, 0, 1'b0, -1, 1'b1);
        chk("t3_ar1_wrap", DATA_W'(ar_log[1]), DATA_W'(32'h0000_0000));
        chk("t3_err_held", DATA_W'(io_err), DATA_W'(1));

        // Zero bursts: no AXI traffic, immediate done; clears the previous error.
        run(32'h0000_5000, 16'd0, -1, 0, 1'b0, -1, 1'b0);
        chk("t4_no_ar", DATA_W'(ar_log.size()), DATA_W'(0));

        // Early rlast on the 10th beat of burst 0.
        run(32'h0001_0000, 16'd2, -1, 10, 1'b0, -1, 1'b1);
        chk("t5_ar_count", DATA_W'(ar_log.size()), DATA_W'(2));
        chk("t5_beats", DATA_W'(beats_seen), DATA_W'(74));

        // Reset in the middle of DATA, then a clean recovery run.
        run(32'h0002_0000, 16'd1, -1, 0, 1'b0, 20, 1'b0);
        run(32'h0003_0abc, 16'd1, -1, 0, 1'b1, -1, 1'b0);
        chk("t7_ar0", DATA_W'(ar_log[0]), DATA_W'(32'h0003_0000));

`ifdef AXI4_DMA_READ_CHECKSUM_EN
        pat_k = 1'b1;
        run(32'h0000_0000, 16'd1, -1, 0, 1'b0, -1, 1'b0);
        chk("ck_zero", io_checksum, '0);
        pat_k = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi4_dma_read.md
# axi4_dma_read

AXI4 read-master DMA engine: on an `ap_start` pulse it reads `io_num_burst` consecutive full-width bursts starting at `io_start_addr`. It forwards every returned beat to a downstream valid/ready stream. It is the read-side counterpart of the DMA write engine, sits on the same 512-bit memory port, and uses the same HLS-style `ap_*` control handshake.

## Interface
Parameters:
- `ADDR_W`, 32, AXI address width.
- `DATA_W`, 512, AXI data width in bits (byte count = DATA_W/8).
- `ID_W`, 1, AXI ID width.
- `BURST_BEATS`, 64, beats per burst; `arlen` = BURST_BEATS-1.
- `CNT_W`, 16, width of the burst-count input.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `io_axi_arvalid`/`io_axi_arready`  out/in  1  AR handshake.
- `io_axi_araddr`  out  ADDR_W  burst address.
- `io_axi_arid`  out  ID_W  constant 0.
- `io_axi_arlen`  out  8  constant BURST_BEATS-1.
- `io_axi_arsize`  out  3  constant log2(DATA_W/8).
- `io_axi_arburst`  out  2  constant 2'b01 (INCR).
- `io_axi_rvalid`/`io_axi_rready`  in/out  1  R handshake.
- `io_axi_rdata`  in  DATA_W  read data.
- `io_axi_rid`  in  ID_W  ignored.
- `io_axi_rresp`  in  2  response.
- `io_axi_rlast`  in  1  last beat of burst.
- `io_rd_valid`/`io_rd_ready`  out/in  1  output stream handshake.
- `io_rd_data`  out  DATA_W  output beat.
- `io_start_addr`  in  ADDR_W  base address; low 12 bits forced to 0.
- `io_num_burst`  in  CNT_W  number of bursts.
- `io_ap_start`  in  1  start request.
- `io_ap_ready`, `io_ap_done`, `io_ap_idle`  out  1  control status.
- `io_err`  out  1  sticky error flag.

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - `ap_idle`=1.
  - When `ap_start`=1, latch `start_addr & ~0xFFF` into `addr_r`, latch `num_burst`, and clear `burst_cnt`, `beat_cnt` and `io_err`.
  - Go to ADDR, or to DONE if `num_burst`==0.
- ADDR:
  - `arvalid`=1 and `araddr`=`addr_r`.
  - On `arready`, go to DATA.
- DATA: pass-through.
  - `io_rd_valid`=`rvalid`, `io_rd_data`=`rdata`, `rready`=`io_rd_ready`.
  - `beat_cnt` increments on each R handshake.
- Last beat handshake (beat with `rlast`=1):
  - Clear `beat_cnt` and add BURST_BEATS·DATA_W/8 to `addr_r` (4096 at defaults; modulo 2^ADDR_W).
  - Increment `burst_cnt`.
  - Go to DONE if `burst_cnt`==`num_burst`-1, else to ADDR.
- Errors, set in DATA and sticky until the next start:
  - `rresp`≠OKAY on any handshake sets `io_err`.
  - `rlast` disagreeing with (`beat_cnt`==BURST_BEATS-1) sets `io_err`.
  - The FSM advances only on `rlast`.
- DONE: `ap_done`=`ap_ready`=1 for exactly one cycle, then go to IDLE.
- One burst outstanding at a time; AR and R never overlap.
- `ap_start` outside IDLE is ignored.

## Timing
- Reset values:
  - State IDLE; all counters and `addr_r` = 0.
  - `arvalid`=0, `rready`=0, `io_rd_valid`=0.
  - `ap_idle`=1, `ap_done`=0, `ap_ready`=0, `io_err`=0.
- `ap_start` in cycle N drives `arvalid` high in N+1.
- AR handshake in cycle N makes `rready` eligible in N+1.
- R→stream path is combinational: zero latency, no buffering.
- `arvalid`, `araddr` and the constant AR fields are registered/stable until `arready`.
- Final `rlast` handshake in cycle N gives `ap_done` in N+1 and `ap_idle` in N+2.
- `num_burst`=0: `ap_done` one cycle after `ap_start`, with no AXI traffic.
- Synchronous `reset` mid-transfer forces IDLE on the next edge and drops `rready`/`arvalid`. Draining in-flight AXI data is the system's responsibility.

## Configuration
- `AXI4_DMA_READ_CHECKSUM_EN` defined:
  - Adds output `io_checksum` [DATA_W-1:0], the XOR of all beats accepted since the last start.
  - It is cleared on start and on reset, and valid when `ap_done`=1.
- Undefined: no port and no logic.

## Structure
- Shared package `axi4_dma_pkg`:
  - FSM state enum.
  - AXI constants: `BURST_INCR`=2'b01, `RESP_OKAY`=2'b00.
  - Function `axsize_of(DATA_W)`.
  - The 4 KiB alignment mask, shared with the write engine.
- No sub-module needed; a single flat module.

## Test plan
- Start with `start_addr`=0x0000_1234 and `num_burst`=2, slave always ready → ARs at 0x1000 then 0x2000, each with `arlen`=63; 128 beats forwarded in order; `ap_done` one cycle after the second `rlast`; `io_err`=0.
- Same run with `io_rd_ready` toggling randomly at 50% → `rready` mirrors it; no beat lost or duplicated; data matches the memory model.
- `num_burst`=0 → no `arvalid` ever; `ap_done`/`ap_ready` pulse in the cycle after start.
- Slave returns `rresp`=2'b10 on beat 5 → `io_err`=1 through DONE; transfer still completes; `io_err` clears on the next start.
- `rlast` asserted on beat 10 → `io_err`=1, next AR issued; reset mid-DATA → the next cycle shows `ap_idle`=1 and `arvalid`=`rready`=0.
- With `AXI4_DMA_READ_CHECKSUM_EN`, one burst of beats {k replicated across the word}, k=0..63 → `io_checksum`=0 at done (XOR of 0..63).
